// File: rtl/rom_loader_pkg.sv
// rom_loader shared definitions: FSM states, frame constants.
// LOADER_CHECKSUM_EN (in rom_loader) enables the CSUM state.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_FIN,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [7:0]  CSUM_OK        = 8'h00;

  function automatic logic in_frame(state_e s);
    return s inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// rom_loader byte-stream handshake and ROM write port.
// slave = loader side, master = stream source / ROM observer.
interface rom_loader_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output rom_we,
    output rom_waddr,
    output rom_wdata
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  rom_we,
    input  rom_waddr,
    input  rom_wdata
  );

endinterface

// File: rtl/loader_timeout.sv
// loader_timeout: saturating count of cycles since the last clear.
// expired fires on the cycle the count would reach LIMIT.
module loader_timeout #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // clr loads 1: the clearing cycle itself is the first one elapsed
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = W'(1);
    end else if (en && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en & ~clr & (cnt_q >= W'(LIMIT - 1));

endmodule

// File: rtl/rom_loader.sv
// rom_loader: boot-time ROM writer; packs a framed byte stream into words.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit checksum byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  rom_loader_if.slave bus,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  state_e state_q, state_d;

  logic              rx_ready;
  logic              acc;
  logic              launch;
  logic              tmo;
  logic [15:0]       len_n;
  logic              len_bad;
  logic              word_end;
  logic              last_word;
  logic [7:0]        len_lo_q;
  logic [ADDR_W-1:0] last_q;
  logic [ADDR_W-1:0] widx_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [1:0]        lane_q;
  logic [23:0]       asm_q;
  logic              we_q;
  logic [31:0]       wdata_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_sum;
  assign csum_sum = csum_q + bus.rx_data;
`endif

  assign acc       = bus.rx_valid & rx_ready;
  assign launch    = start &
                     (state_q inside {S_IDLE, S_DONE, S_ERR});
  assign len_n     = {bus.rx_data, len_lo_q};
  assign len_bad   = (len_n == 16'd0) ||
                     ({16'd0, len_n} > 32'(MAX_WORDS));
  assign word_end  = acc & (state_q == S_DATA) &
                     (lane_q == 2'(BYTES_PER_WORD - 1));
  assign last_word = word_end & (widx_q == last_q);

  loader_timeout #(
    .LIMIT(TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc | launch),
    .en      (rx_ready),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (launch) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (acc)      state_d = S_LEN1;
        else if (tmo) state_d = S_ERR;
      end
      S_LEN1: begin
        if (acc)      state_d = len_bad ? S_ERR : S_DATA;
        else if (tmo) state_d = S_ERR;
      end
      S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_word)     state_d = S_CSUM;
`else
        if (last_word)     state_d = S_FIN;
`endif
        else if (tmo)      state_d = S_ERR;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (acc)
          state_d = (csum_sum == CSUM_OK) ? S_DONE : S_ERR;
        else if (tmo)
          state_d = S_ERR;
      end
`endif
      // last word is on the write port this cycle
      S_FIN:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready = 1'b0;
    core_rst = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    unique case (1'b1)
      (state_q == S_DONE): begin
        core_rst = 1'b1;
        done     = 1'b1;
      end
      (state_q == S_ERR): err = 1'b1;
      in_frame(state_q):  rx_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo_q <= '0;
      last_q   <= '0;
      widx_q   <= '0;
      lane_q   <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      we_q <= word_end;
      if (acc && state_q == S_LEN0) begin
        len_lo_q <= bus.rx_data;
      end
      if (acc && state_q == S_LEN1) begin
        last_q <= ADDR_W'(len_n - 16'd1);
        widx_q <= '0;
        lane_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q <= '0;
`endif
      end
      // byte 0 shifts down to [7:0] by the time byte 3 arrives
      if (acc && state_q == S_DATA) begin
        lane_q <= lane_q + 2'd1;
        asm_q  <= {bus.rx_data, asm_q[23:8]};
`ifdef LOADER_CHECKSUM_EN
        csum_q <= csum_sum;
`endif
      end
      if (word_end) begin
        waddr_q <= widx_q;
        wdata_q <= {bus.rx_data, asm_q};
        widx_q  <= widx_q + 1'b1;
      end
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.rom_we    = we_q;
  assign bus.rom_waddr = waddr_q;
  assign bus.rom_wdata = wdata_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized frames, scoreboard on the ROM write port.
// Works with or without LOADER_CHECKSUM_EN.
module tb_rom_loader;

  localparam int ADDR_W = 12;
  localparam int MAXW   = 16;
  localparam int TMO    = 16;
`ifdef LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 1;
`else
  localparam int DONE_LAT = 2;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_rst, done, err;

  rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

  rom_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (MAXW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus.slave),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int last_acc = 0;
  int stalls = 0;
  int we_count = 0;
  int last_we_cyc = 0;
  wr_t exp_q[$];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every ROM write is popped against the scoreboard
  always @(negedge clk) begin
    if (rst && bus.rom_we) begin
      wr_t e;
      compared++;
      we_count++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_we: got %0h:%08h want none",
                 bus.rom_waddr, bus.rom_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.rom_waddr !== e.addr ||
            bus.rom_wdata !== e.data) begin
          mismatched++;
          $display("FAIL rom_write: got %0h:%08h want %0h:%08h",
                   bus.rom_waddr, bus.rom_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    if (!bus.rx_ready) stalls++;
    while (!bus.rx_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_ready: got 0 want 1");
    end
    last_acc = cyc;
    @(posedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_outcome(input bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      n++;
    end while (!(done || err) && n < 100);
    if (!(done || err)) begin
      compared++;
      mismatched++;
      $display("FAIL outcome_timeout: got none want %0d", ok);
    end else begin
      chk("done", done, 32'(ok));
      chk("err", err, 32'(!ok));
      chk("core_rst", core_rst, 32'(ok));
      chk("latency", cyc - last_acc, ok ? DONE_LAT : 1);
`ifndef LOADER_CHECKSUM_EN
      if (ok) chk("done_after_we", cyc - last_we_cyc, 1);
`endif
      chk("exp_q_left", exp_q.size(), 0);
    end
  endtask

  // Reference: words are LE packs of payload, sum of bytes mod 256
  task automatic frame(input int n, input bq_t pl, input int maxgap,
                       input bit bad_csum, input bit mid_start);
    bit ok;
    logic [7:0] s;
    logic [31:0] w;
    wr_t e;
    ok = (n >= 1 && n <= MAXW);
    s = 8'h00;
    foreach (pl[i]) s = s + pl[i];
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = 32'(pl[4*i]) + 32'(pl[4*i+1]) * 256 +
            32'(pl[4*i+2]) * 65536 + 32'(pl[4*i+3]) * 16777216;
        e.addr = ADDR_W'(i);
        e.data = w;
        exp_q.push_back(e);
      end
    end
    do_start();
    send_byte(8'(n), $urandom_range(0, maxgap));
    send_byte(8'(n >> 8), $urandom_range(0, maxgap));
    if (ok) begin
      for (int i = 0; i < 4 * n; i++) begin
        send_byte(pl[i], $urandom_range(0, maxgap));
        if (mid_start && i == 2) do_start();
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'(0) - s + 8'(bad_csum), $urandom_range(0, maxgap));
      ok = !bad_csum;
`endif
    end
    wait_outcome(ok);
  endtask

  function automatic bq_t rnd_pl(input int n);
    bq_t q;
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bq_t pl;
    bit rdy_seen;
    int base;
    int c5;
    int n;
    wr_t e;
    logic [7:0] b;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: stray valid must not be taken
    rdy_seen = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    repeat (10) begin
      @(negedge clk);
      if (bus.rx_ready) rdy_seen = 1'b1;
    end
    bus.rx_valid = 1'b0;
    chk("rst_rx_ready", 32'(rdy_seen), 0);
    chk("rst_core_rst", core_rst, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_waddr", bus.rom_waddr, 0);
    chk("rst_wdata", bus.rom_wdata, 0);
    chk("rst_we_count", we_count, 0);

    pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    frame(2, pl, 0, 1'b0, 1'b0);

    rdy_seen = 1'b0;
    bus.rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.rx_ready) rdy_seen = 1'b1;
    end
    bus.rx_valid = 1'b0;
    chk("done_rx_ready", 32'(rdy_seen), 0);

    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    frame(1, pl, 0, 1'b0, 1'b0);
    frame(1, pl, 0, 1'b1, 1'b0);

    pl = {};
    frame(0, pl, 0, 1'b0, 1'b0);
    frame(3, rnd_pl(3), 1, 1'b0, 1'b0);
    frame(MAXW + 1, pl, 0, 1'b0, 1'b0);
    frame(MAXW, rnd_pl(MAXW), 1, 1'b0, 1'b0);

    // Timeout: N=2, five payload bytes then silence
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    pl = rnd_pl(2);
    e.addr = '0;
    e.data = 32'(pl[0]) + 32'(pl[1]) * 256 +
             32'(pl[2]) * 65536 + 32'(pl[3]) * 16777216;
    exp_q.push_back(e);
    base = we_count;
    for (int i = 0; i < 5; i++) send_byte(pl[i], 0);
    c5 = last_acc;
    n = 0;
    do begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      n++;
    end while (!err && n < 64);
    chk("tmo_err", err, 1);
    chk("tmo_latency", cyc - c5, TMO);
    chk("tmo_writes", we_count - base, 1);
    chk("tmo_core_rst", core_rst, 0);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, MAXW);
      frame(n, rnd_pl(n), 2, 1'b0, k == 2);
    end

    stalls = 0;
    frame(8, rnd_pl(8), 0, 1'b0, 1'b0);
    chk("stream_stalls", stalls, 0);

    // Async reset after the third write of a streaming frame
    stalls = 0;
    pl = rnd_pl(8);
    for (int i = 0; i < 8; i++) begin
      e.addr = ADDR_W'(i);
      e.data = 32'(pl[4*i]) + 32'(pl[4*i+1]) * 256 +
               32'(pl[4*i+2]) * 65536 + 32'(pl[4*i+3]) * 16777216;
      exp_q.push_back(e);
    end
    do_start();
    send_byte(8'h08, 0);
    send_byte(8'h00, 0);
    base = we_count;
    for (int i = 0; i < 32; i++) begin
      b = pl[i];
      send_byte(b, 0);
      if (we_count - base == 3) break;
    end
    chk("ar_writes", we_count - base, 3);
    chk("ar_stalls", stalls, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_rom_we", bus.rom_we, 0);
    chk("ar_waddr", bus.rom_waddr, 0);
    chk("ar_wdata", bus.rom_wdata, 0);
    chk("ar_rx_ready", bus.rx_ready, 0);
    chk("ar_core_rst", core_rst, 0);
    chk("ar_done_err", {done, err}, 0);
    exp_q.delete();
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    frame(4, rnd_pl(4), 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
